sram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the board's external asynchronous SRAM (20-bit word address, 16-bit data, active-low CE/WE/OE/LB/UB) inside Minimal_SoC. Port A is the sensor-data logger (writes), port B is the downlink readout path (reads and writes). The block grants one requester at a time with round-robin fairness and drives the SRAM pins through fixed setup, strobe, hold and turnaround phases.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_rr_arb.sv | 34 +++
 rtl/sram_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared state encoding, pin polarity and default widths for the SRAM arbiter
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    TURN   = 3'd4
  } state_t;

  localparam logic SRAM_ASSERT   = 1'b0;
  localparam logic SRAM_DEASSERT = 1'b1;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/sram_rr_arb.sv
// rtl/sram_rr_arb.sv - two-way round-robin picker with registered grant pulses
module sram_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic accept,
  output logic pick_b,
  output logic gnt_a,
  output logic gnt_b
);

  // last_b resets high so that port A wins the first tie
  logic last_b;

  always_comb begin
    pick_b = req_b & (~req_a | ~last_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
    end else begin
      gnt_a <= accept & ~pick_b;
      gnt_b <= accept & pick_b;
      if (accept) begin
        last_b <= pick_b;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter and setup/strobe/hold/turn sequencer for the async SRAM
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W
) (
  input  logic              SYSCLK,
  input  logic              NSYSRESET,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [1:0]        be_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [1:0]        be_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              done_a,
  output logic              done_b,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] SRAM_ADDRESS,
  inout  wire  [DATA_W-1:0] SRAM_DATA,
  output logic              SRAM_CE,
  output logic              SRAM_WE,
  output logic              SRAM_OE,
  output logic              SRAM_LB,
  output logic              SRAM_UB
);

  localparam int              LANE_W      = DATA_W / 2;
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               acc_we;
  logic               acc_b;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic [1:0]         acc_be;
  logic               accept;
  logic               pick_b;
  logic               last_strobe;
  logic               data_oe;

  assign accept      = (state == IDLE) && (req_a || req_b);
  assign last_strobe = (state == STROBE) && (cnt == '0);

  sram_rr_arb u_rr_arb (
    .clk    (SYSCLK),
    .rst_n  (NSYSRESET),
    .req_a  (req_a),
    .req_b  (req_b),
    .accept (accept),
    .pick_b (pick_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b)
  );

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   state_nx = STROBE;
      STROBE:  if (cnt == '0) state_nx = HOLD;
      HOLD:    state_nx = acc_we ? IDLE : TURN;
      TURN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // CE brackets WE/OE by one cycle on each side, so the strobes never move with CE
  always_comb begin
    SRAM_CE = SRAM_DEASSERT;
    SRAM_WE = SRAM_DEASSERT;
    SRAM_OE = SRAM_DEASSERT;
    SRAM_LB = SRAM_DEASSERT;
    SRAM_UB = SRAM_DEASSERT;
    data_oe = 1'b0;
    done_a  = 1'b0;
    done_b  = 1'b0;
    busy    = (state != IDLE);
    case (state)
      SETUP, STROBE, HOLD: begin
        SRAM_CE = SRAM_ASSERT;
        SRAM_LB = acc_be[0] ? SRAM_ASSERT : SRAM_DEASSERT;
        SRAM_UB = acc_be[1] ? SRAM_ASSERT : SRAM_DEASSERT;
        data_oe = acc_we;
        if (state == STROBE) begin
          if (acc_we) begin
            SRAM_WE = SRAM_ASSERT;
          end else begin
            SRAM_OE = SRAM_ASSERT;
          end
        end
        if (state == HOLD) begin
          done_a = ~acc_b;
          done_b = acc_b;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      acc_we    <= 1'b0;
      acc_b     <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      acc_be    <= '0;
      cnt       <= '0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        acc_b     <= pick_b;
        acc_we    <= pick_b ? we_b    : we_a;
        acc_addr  <= pick_b ? addr_b  : addr_a;
        acc_wdata <= pick_b ? wdata_b : wdata_a;
        acc_be    <= pick_b ? be_b    : be_a;
      end
      if (state == SETUP) begin
        cnt <= STROBE_LOAD;
      end else if ((state == STROBE) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      // disabled byte lanes read back as zero
      if (last_strobe && !acc_we) begin
        rdata <= SRAM_DATA & {{LANE_W{acc_be[1]}}, {LANE_W{acc_be[0]}}};
      end
    end
  end

  assign SRAM_ADDRESS = acc_addr;
  assign SRAM_DATA    = data_oe ? acc_wdata : 'z;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
`timescale 1ns/1ps
module tb_sram_arbiter;

  logic SYSCLK = 1'b0;
  logic NSYSRESET = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  int total = 0;
  int bad = 0;

  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [19:0] addr_a = '0, addr_b = '0;
  logic [15:0] wdata_a = '0, wdata_b = '0;
  logic [1:0]  be_a = '0, be_b = '0;
  logic        gnt_a, gnt_b, done_a, done_b, busy;
  logic [15:0] rdata;
  logic [19:0] sram_addr;
  wire  [15:0] sram_data;
  logic        ce, we_n, oe, lb, ub;

  logic [15:0] mem [0:1048575];

  // async SRAM model: drives the full word on reads, commits enabled lanes while WE is low
  assign sram_data = (!ce && !oe && we_n) ? mem[sram_addr] : 16'hzzzz;
  always @(negedge SYSCLK) begin
    if (!ce && !we_n) begin
      if (!lb) mem[sram_addr][7:0]  <= sram_data[7:0];
      if (!ub) mem[sram_addr][15:8] <= sram_data[15:8];
    end
  end

  sram_arbiter #(.WAIT_CYCLES(2)) dut (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .be_a(be_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .be_b(be_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .rdata(rdata), .busy(busy), .SRAM_ADDRESS(sram_addr), .SRAM_DATA(sram_data),
    .SRAM_CE(ce), .SRAM_WE(we_n), .SRAM_OE(oe), .SRAM_LB(lb), .SRAM_UB(ub)
  );

  logic        x_req = 1'b0, x_we = 1'b0;
  logic [19:0] x_addr = '0;
  logic [15:0] x_wdata = '0;
  logic [1:0]  x_be = '0;

  logic        g1a, g1b, d1a, d1b, busy1, ce1, we1, oe1, lb1, ub1;
  logic [15:0] rdata1;
  logic [19:0] addr1;
  wire  [15:0] bus1;
  logic        g15a, g15b, d15a, d15b, busy15, ce15, we15, oe15, lb15, ub15;
  logic [15:0] rdata15;
  logic [19:0] addr15;
  wire  [15:0] bus15;

  sram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET),
    .req_a(x_req), .we_a(x_we), .addr_a(x_addr), .wdata_a(x_wdata), .be_a(x_be),
    .req_b(1'b0), .we_b(1'b0), .addr_b(20'h0), .wdata_b(16'h0), .be_b(2'b00),
    .gnt_a(g1a), .gnt_b(g1b), .done_a(d1a), .done_b(d1b),
    .rdata(rdata1), .busy(busy1), .SRAM_ADDRESS(addr1), .SRAM_DATA(bus1),
    .SRAM_CE(ce1), .SRAM_WE(we1), .SRAM_OE(oe1), .SRAM_LB(lb1), .SRAM_UB(ub1)
  );

  sram_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET),
    .req_a(x_req), .we_a(x_we), .addr_a(x_addr), .wdata_a(x_wdata), .be_a(x_be),
    .req_b(1'b0), .we_b(1'b0), .addr_b(20'h0), .wdata_b(16'h0), .be_b(2'b00),
    .gnt_a(g15a), .gnt_b(g15b), .done_a(d15a), .done_b(d15b),
    .rdata(rdata15), .busy(busy15), .SRAM_ADDRESS(addr15), .SRAM_DATA(bus15),
    .SRAM_CE(ce15), .SRAM_WE(we15), .SRAM_OE(oe15), .SRAM_LB(lb15), .SRAM_UB(ub15)
  );

  task automatic step();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({ce, we_n, oe, lb, ub} !== 5'b11111) begin
      bad++; $display("FAIL reset_ctrl: got %b want 11111", {ce, we_n, oe, lb, ub});
    end
    total++;
    if ({gnt_a, gnt_b, done_a, done_b, busy, dut.data_oe} !== 6'b0) begin
      bad++; $display("FAIL reset_status: got %b want 000000", {gnt_a, gnt_b, done_a, done_b, busy, dut.data_oe});
    end
    total++;
    if (sram_addr !== 20'h0 || rdata !== 16'h0) begin
      bad++; $display("FAIL reset_regs: addr=%h rdata=%h want 0/0", sram_addr, rdata);
    end
    @(negedge SYSCLK);
    NSYSRESET = 1'b1;
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_release: busy=%b want 0", busy);
    end
  endtask

  task automatic test_write_a();
    logic [8:0] got, exp;
    req_a = 1'b1; we_a = 1'b1; addr_a = 20'h00010; wdata_a = 16'hBEEF; be_a = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) req_a = 1'b0;
      got = {gnt_a, done_a, ce, we_n, oe, lb, ub, dut.data_oe, busy};
      exp = {k == 1, k == 4, !(k <= 4), !(k == 2 || k == 3), 1'b1, !(k <= 4), !(k <= 4), k <= 4, k <= 4};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL write_a cycle %0d: got %b want %b", k, got, exp);
      end
      if (k == 2) begin
        total++;
        if (sram_addr !== 20'h00010 || sram_data !== 16'hBEEF) begin
          bad++; $display("FAIL write_a_bus: addr=%h data=%h want 00010/beef", sram_addr, sram_data);
        end
      end
    end
    total++;
    if (mem[20'h00010] !== 16'hBEEF) begin
      bad++; $display("FAIL write_a_mem: got %h want beef", mem[20'h00010]);
    end
  endtask

  task automatic test_read_b_lanes();
    logic [1:0]  bes [3];
    logic [15:0] want [3];
    logic [8:0]  got, exp;
    bes[0] = 2'b10; want[0] = 16'hBE00;
    bes[1] = 2'b01; want[1] = 16'h00EF;
    bes[2] = 2'b00; want[2] = 16'h0000;
    for (int v = 0; v < 3; v++) begin
      req_b = 1'b1; we_b = 1'b0; addr_b = 20'h00010; wdata_b = 16'hFFFF; be_b = bes[v];
      for (int k = 1; k <= 6; k++) begin
        step();
        if (k == 1) req_b = 1'b0;
        got = {gnt_b, done_b, ce, we_n, oe, lb, ub, dut.data_oe, busy};
        exp = {k == 1, k == 4, !(k <= 4), 1'b1, !(k == 2 || k == 3),
               !(k <= 4 && bes[v][0]), !(k <= 4 && bes[v][1]), 1'b0, k <= 5};
        total++;
        if (got !== exp) begin
          bad++; $display("FAIL read_b be=%b cycle %0d: got %b want %b", bes[v], k, got, exp);
        end
        if (k == 4) begin
          total++;
          if (rdata !== want[v]) begin
            bad++; $display("FAIL read_b_rdata be=%b: got %h want %h", bes[v], rdata, want[v]);
          end
        end
      end
    end
  endtask

  task automatic test_alternate();
    bit exp_a;
    int n, last;
    req_a = 1'b1; we_a = 1'b1; addr_a = 20'h00020; wdata_a = 16'h1111; be_a = 2'b11;
    req_b = 1'b1; we_b = 1'b1; addr_b = 20'h00021; wdata_b = 16'h2222; be_b = 2'b11;
    exp_a = 1'b1; n = 0; last = 0;
    for (int c = 1; c <= 60 && n < 6; c++) begin
      step();
      if (gnt_a || gnt_b) begin
        total++;
        if ({gnt_a, gnt_b} !== (exp_a ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL alternate grant %0d: got %b want %b", n, {gnt_a, gnt_b}, exp_a ? 2'b10 : 2'b01);
        end
        if (n > 0) begin
          total++;
          if (c - last != 5) begin
            bad++; $display("FAIL alternate period: got %0d want 5", c - last);
          end
        end
        last = c; n++; exp_a = !exp_a;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    total++;
    if (n != 6) begin
      bad++; $display("FAIL alternate count: got %0d grants want 6", n);
    end
    wait_idle();
    total++;
    if (mem[20'h00020] !== 16'h1111 || mem[20'h00021] !== 16'h2222) begin
      bad++; $display("FAIL alternate_mem: got %h/%h want 1111/2222", mem[20'h00020], mem[20'h00021]);
    end
  endtask

  task automatic test_wait_cycles();
    int s1, s15, d1, d15, bus_bad;
    x_req = 1'b1; x_we = 1'b1; x_addr = 20'hFFFFF; x_wdata = 16'h1234; x_be = 2'b11;
    s1 = 0; s15 = 0; d1 = 0; d15 = 0; bus_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        x_req = 1'b0;
        total++;
        if (addr1 !== 20'hFFFFF || addr15 !== 20'hFFFFF || !g1a || !g15a) begin
          bad++; $display("FAIL wait_setup: addr %h/%h gnt %b/%b want fffff/fffff 1/1", addr1, addr15, g1a, g15a);
        end
      end
      if (!we1) begin s1++; if (bus1 !== 16'h1234) bus_bad++; end
      if (!we15) begin s15++; if (bus15 !== 16'h1234) bus_bad++; end
      if (d1a) begin d1 = k; if (addr1 !== 20'hFFFFF) bus_bad++; end
      if (d15a) begin d15 = k; if (addr15 !== 20'hFFFFF) bus_bad++; end
    end
    total++;
    if (s1 != 1 || d1 != 3) begin
      bad++; $display("FAIL wait_1: strobe=%0d done=%0d want 1/3", s1, d1);
    end
    total++;
    if (s15 != 15 || d15 != 17) begin
      bad++; $display("FAIL wait_15: strobe=%0d done=%0d want 15/17", s15, d15);
    end
    total++;
    if (bus_bad != 0 || busy1 !== 1'b0 || busy15 !== 1'b0) begin
      bad++; $display("FAIL wait_bus: errors=%0d busy=%b/%b want 0 0/0", bus_bad, busy1, busy15);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    req_a = 1'b1; we_a = 1'b1; addr_a = 20'h00030; wdata_a = 16'h5A5A; be_a = 2'b11;
    step();
    req_a = 1'b0;
    total++;
    if (gnt_a !== 1'b1) begin
      bad++; $display("FAIL reset_mid_gnt: got %b want 1", gnt_a);
    end
    step();
    total++;
    if (we_n !== 1'b0) begin
      bad++; $display("FAIL reset_mid_strobe: we=%b want 0", we_n);
    end
    #2 NSYSRESET = 1'b0;
    #1;
    total++;
    if ({ce, we_n, oe, lb, ub} !== 5'b11111) begin
      bad++; $display("FAIL reset_mid_ctrl: got %b want 11111", {ce, we_n, oe, lb, ub});
    end
    total++;
    if ({dut.data_oe, busy, done_a, sram_addr} !== 23'h0) begin
      bad++; $display("FAIL reset_mid_state: oe=%b busy=%b done=%b addr=%h want 0", dut.data_oe, busy, done_a, sram_addr);
    end
    @(negedge SYSCLK);
    NSYSRESET = 1'b1;
    dones = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (done_a || done_b || busy) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL reset_mid_nodone: %0d active cycles want 0", dones);
    end
    req_a = 1'b1; we_a = 1'b1; addr_a = 20'h00040;
    req_b = 1'b1; we_b = 1'b1; addr_b = 20'h00041;
    step();
    req_a = 1'b0; req_b = 1'b0;
    total++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      bad++; $display("FAIL reset_mid_tie: got %b want 10", {gnt_a, gnt_b});
    end
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge SYSCLK);
    #1;
    test_reset();
    test_write_a();
    test_read_b_lanes();
    test_alternate();
    test_wait_cycles();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
